oh_memory_bist: RTL
===================

Name: oh_memory_bist

Overview:
March C- built-in self-test controller that acts as the initiator for the BIST and read ports of oh_memory_dp, i.e. the other end of that memory interface.
- Drives bist_en/bist_we/bist_wem/bist_addr/bist_din to write patterns.
- Drives rd_en/rd_addr and checks rd_dout against expected data.
- Reports pass/fail, first failing address and error count to a test/config register block.

Parameters:
DW, 104, memory data width (must match the memory)
DEPTH, 32, number of words tested; addresses 0..DEPTH-1
AW, 5, address width; DEPTH <= 2**AW

Ports:
clk  input  1  single clock; drives both wr_clk and rd_clk of the memory under test
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a test run when idle
busy  output  1  high while a run is in progress
done  output  1  sticky; set when a run completes, cleared by the next accepted start
fail  output  1  sticky; set on any read miscompare in the current run
fail_addr  output  AW  address of the first miscompare in the current run
err_count  output  16  miscompare count, saturates at 16'hFFFF
bist_en  output  1  memory BIST mux select; high exactly while busy
bist_we  output  1  BIST write strobe
bist_wem  output  DW  per-bit write enable; all ones when bist_we=1, else zero
bist_addr  output  AW  BIST write address
bist_din  output  DW  BIST write data
rd_en  output  1  memory read enable
rd_addr  output  AW  memory read address
rd_dout  input  DW  memory read data; valid the cycle after rd_en

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset mid-run aborts the run immediately; the next cycle shows all outputs 0.
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
  - IDLE: start=1 clears done, fail, fail_addr and err_count, then moves to M0. start is ignored in any other state.
- March elements. D0 = all zeros, D1 = ~D0.
  - M0: ascending, w D0.
  - M1: ascending, r D0 then w D1.
  - M2: ascending, r D1 then w D0.
  - M3: descending, r D0 then w D1.
  - M4: descending, r D1 then w D0.
  - M5: ascending, r D0.
  - Ascending runs 0..DEPTH-1; descending runs DEPTH-1..0. DEPTH need not be a power of two; the address counter never leaves 0..DEPTH-1.
- Operation issue: one operation per cycle.
  - Read cycle: rd_en=1, rd_addr=addr, bist_we=0.
  - Write cycle: bist_we=1, bist_addr=addr, bist_din=pattern, rd_en=0.
  - Read-then-write elements issue the read in cycle N and the write to the same address in cycle N+1.
- Compare pipeline: on each read, register expected data, address and a valid bit. The following cycle compares rd_dout with expected.
  - On mismatch: err_count++ (saturating). If fail=0, set fail=1 and load fail_addr.
- Timing: start is sampled at edge T0 and busy=1 from T0+1. The 10*DEPTH operations occupy cycles T0+1..T0+10*DEPTH. DRAIN (the final compare) is cycle T0+10*DEPTH+1. At T0+10*DEPTH+2: busy=0, bist_en=0, done=1, state DONE.
- DONE: behaves as IDLE, and start restarts a run. done, fail, fail_addr and err_count hold until the next accepted start or reset.

Optional Feature:
OH_MEMORY_BIST_CHECKER_EN:
- Defined: D0 for address a = {DW/2{2'b01}} when a[0]=0, else {DW/2{2'b10}}; D1 = ~D0 (checkerboard background, bit- and address-alternating; DW even). Expected read data uses the same function of rd_addr.
- Undefined: solid background, D0 = all zeros. No extra logic is compiled.

Test Plan:
- Fault-free memory, DEPTH=32: start at T0 -> busy 1 for T0+1..T0+321; done=1 at T0+322; fail=0; err_count=0; bist_en deasserted together with busy.
- Address 5 bit 3 stuck-at-1 -> M1, M3 and M5 reads miscompare; fail=1, fail_addr=5, err_count=3.
- Address 5 stuck-at-0 plus address 9 stuck-at-0 -> M2/M4 miscompares at both addresses; fail_addr=5 (first, from M2 ascending), err_count=4.
- DEPTH=5, AW=3: rd_addr/bist_addr never exceed 4; M3 starts at address 4; done at T0+52.
- start pulses during busy are ignored (run length unchanged). reset at T0+100 -> all outputs 0 next cycle; a new start runs a full clean pass.
- With OH_MEMORY_BIST_CHECKER_EN: M0 writes to address 0 show bist_din=...0101 and to address 1 show ...1010. A coupling fault (write to address 2 flips bit 0 of address 3) is detected with fail_addr=3.

Source files
------------

// File: rtl/oh_memory_bist.sv
// March C- BIST initiator for the BIST write port and read port of oh_memory_dp.
// Define OH_MEMORY_BIST_CHECKER_EN for a checkerboard background instead of solid zeros.
module oh_memory_bist #(
  parameter int DW    = 104,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [15:0]   err_count,
  output logic          bist_en,
  output logic          bist_we,
  output logic [DW-1:0] bist_wem,
  output logic [AW-1:0] bist_addr,
  output logic [DW-1:0] bist_din,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_dout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q;
  state_t        state_d;
  state_t        elem_nxt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic          phase_q;
  logic          phase_d;

  logic          march;
  logic          rmw;
  logic          desc;
  logic          inv;
  logic          is_wr;
  logic          is_rd;
  logic          elem_end;
  logic          accept;
  logic [DW-1:0] bg;
  logic [DW-1:0] pat;

  logic          cmp_vld;
  logic [DW-1:0] cmp_exp;
  logic [AW-1:0] cmp_addr;
  logic          miscmp;

  logic          done_q;
  logic          fail_q;
  logic [AW-1:0] fail_addr_q;
  logic [15:0]   err_q;

`ifdef OH_MEMORY_BIST_CHECKER_EN
  assign bg = addr_q[0] ? {DW/2{2'b10}} : {DW/2{2'b01}};
`else
  assign bg = '0;
`endif

  // inv selects D1: the write half of M1/M3, the read half of M2/M4
  always_comb begin
    march    = 1'b0;
    rmw      = 1'b0;
    desc     = 1'b0;
    inv      = 1'b0;
    elem_nxt = S_IDLE;
    unique case (state_q)
      S_M0: begin
        march    = 1'b1;
        elem_nxt = S_M1;
      end
      S_M1: begin
        march    = 1'b1;
        rmw      = 1'b1;
        inv      = phase_q;
        elem_nxt = S_M2;
      end
      S_M2: begin
        march    = 1'b1;
        rmw      = 1'b1;
        inv      = ~phase_q;
        elem_nxt = S_M3;
      end
      S_M3: begin
        march    = 1'b1;
        rmw      = 1'b1;
        desc     = 1'b1;
        inv      = phase_q;
        elem_nxt = S_M4;
      end
      S_M4: begin
        march    = 1'b1;
        rmw      = 1'b1;
        desc     = 1'b1;
        inv      = ~phase_q;
        elem_nxt = S_M5;
      end
      S_M5: begin
        march    = 1'b1;
        elem_nxt = S_DRAIN;
      end
      default: ;
    endcase
  end

  assign is_wr    = (state_q == S_M0) | (rmw & phase_q);
  assign is_rd    = (state_q == S_M5) | (rmw & ~phase_q);
  assign elem_end = addr_q == (desc ? '0 : LAST);
  assign pat      = bg ^ {DW{inv}};
  assign accept   = start &
                    ((state_q == S_IDLE) | (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    unique case (1'b1)
      accept: begin
        state_d = S_M0;
        addr_d  = '0;
        phase_d = 1'b0;
      end
      (state_q == S_DRAIN): begin
        state_d = S_DONE;
      end
      march: begin
        if (rmw & ~phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (elem_end) begin
            state_d = elem_nxt;
            addr_d  = ((elem_nxt == S_M3) |
                       (elem_nxt == S_M4)) ? LAST : '0;
          end else if (desc) begin
            addr_d = addr_q - 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign miscmp = cmp_vld & (rd_dout != cmp_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cmp_vld     <= 1'b0;
      cmp_exp     <= '0;
      cmp_addr    <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_q       <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      cmp_vld  <= is_rd;
      cmp_exp  <= pat;
      cmp_addr <= addr_q;
      if (state_q == S_DRAIN) begin
        done_q <= 1'b1;
      end
      if (accept) begin
        done_q      <= 1'b0;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        err_q       <= '0;
      end else if (miscmp) begin
        if (err_q != 16'hFFFF) begin
          err_q <= err_q + 16'd1;
        end
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= cmp_addr;
        end
      end
    end
  end

  assign busy      = march | (state_q == S_DRAIN);
  assign bist_en   = busy;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign err_count = err_q;
  assign bist_we   = is_wr;
  assign bist_wem  = {DW{is_wr}};
  assign bist_addr = is_wr ? addr_q : '0;
  assign bist_din  = is_wr ? pat : '0;
  assign rd_en     = is_rd;
  assign rd_addr   = is_rd ? addr_q : '0;

endmodule
